svfloat_addsub_seq: RTL and testbench

Multi-cycle floating-point adder/subtractor with valid/ready handshakes on both sides. It sits directly downstream of the sign-negation stage, which conditionally flips operand B's sign to implement subtraction. Alignment and normalisation shift one bit per cycle, so the datapath stays small and latency depends on the data. Rounding is round-to-nearest-even only.

---
 rtl/svfloat_addsub_seq_pkg.sv | 60 ++++++
 rtl/svfloat_addsub_seq_neg.sv | 21 ++
 rtl/svfloat_addsub_seq.sv | 207 ++++++++++++++++++++
 tb/tb_svfloat_addsub_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/svfloat_addsub_seq_pkg.sv
// Shared types and helpers for the sequential float32 adder/subtractor:
// float layout, FSM state enum, canonical NaN and operand unpack helpers.
package svfloat_addsub_seq_pkg;

  localparam int unsigned E    = 8;             // exponent width
  localparam int unsigned M    = 23;            // mantissa width
  localparam int unsigned SW   = M + 5;         // carry, hidden, M, G, R, S
  localparam int unsigned XW   = E + 1;         // working exponent (room for carry)
  localparam int unsigned DMAX = M + 3;         // alignment shift saturation
  localparam int unsigned DW   = $clog2(DMAX + 1);

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] man;
  } float_t;

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, ROUND, DONE
  } addsub_state_t;

  // Canonical quiet NaN: +, exponent all ones, mantissa MSB only.
  function automatic float_t ffunc_canon_nan();
    float_t f;
    f.sign = 1'b0;
    f.exp  = '1;
    f.man  = {1'b1, {(M-1){1'b0}}};
    return f;
  endfunction

  function automatic logic is_nan(input float_t f);
    return (&f.exp) && (|f.man);
  endfunction

  function automatic logic is_snan(input float_t f);
    return (&f.exp) && (|f.man) && !f.man[M-1];
  endfunction

  function automatic logic is_inf(input float_t f);
    return (&f.exp) && !(|f.man);
  endfunction

  function automatic logic is_zero(input float_t f);
    return !(|f.exp) && !(|f.man);
  endfunction

  function automatic logic hidden_bit(input float_t f);
    return |f.exp;
  endfunction

  // Subnormals behave as exponent 1 with a hidden bit of 0.
  function automatic logic [E-1:0] eff_exp(input float_t f);
    return (f.exp == '0) ? E'(1) : f.exp;
  endfunction

  function automatic logic [SW-1:0] unpack_sig(input float_t f);
    return {1'b0, hidden_bit(f), f.man, 3'b000};
  endfunction

endpackage

// File: rtl/svfloat_addsub_seq_neg.sv
// Sign-negation stage: flips the operand sign when i_neg is set, leaving
// NaNs untouched when i_presv_nan is set.
//   i_a          operand in
//   i_neg        negate request
//   i_presv_nan  keep NaN payload/sign unchanged
//   o_y_c        operand out (combinational)
module svfloat_addsub_seq_neg
  import svfloat_addsub_seq_pkg::*;
(
  input  float_t i_a,
  input  logic   i_neg,
  input  logic   i_presv_nan,
  output float_t o_y_c
);

  always_comb begin
    o_y_c = i_a;
    if (i_neg && !(i_presv_nan && is_nan(i_a))) o_y_c.sign = ~i_a.sign;
  end

endmodule

// File: rtl/svfloat_addsub_seq.sv
// Multi-cycle float32 add/subtract, one-bit-per-cycle align and normalise,
// round-to-nearest-even.
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (a, b, sub)
//   out_valid / out_ready result handshake (res, flags={invalid,overflow,inexact})
module svfloat_addsub_seq
  import svfloat_addsub_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  float_t     a,
  input  float_t     b,
  input  logic       sub,
  output logic       out_valid,
  input  logic       out_ready,
  output float_t     res,
  output logic [2:0] flags
);

  addsub_state_t   r_state, w_state_nxt;
  logic            r_sx, w_sx_nxt;
  logic            r_sub_eff, w_sub_eff_nxt;
  logic [XW-1:0]   r_ex, w_ex_nxt;
  logic [SW-1:0]   r_x, w_x_nxt;
  logic [SW-1:0]   r_y, w_y_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  float_t          r_res, w_res_nxt;
  logic [2:0]      r_flags, w_flags_nxt;
  logic            r_out_valid, w_out_valid_nxt;

  float_t          w_b;

  svfloat_addsub_seq_neg u_svfloat_neg (
    .i_a         (b),
    .i_neg       (sub),
    .i_presv_nan (1'b1),
    .o_y_c       (w_b)
  );

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign flags     = r_flags;

  // Special-operand detection and result.
  logic   w_special, w_spec_inv;
  float_t w_spec_res;
  always_comb begin
    w_spec_res = '0;
    w_spec_inv = 1'b0;
    w_special  = is_nan(a) || is_nan(w_b) || is_inf(a) || is_inf(w_b) ||
                 (is_zero(a) && is_zero(w_b));
    if (is_nan(a) || is_nan(w_b)) begin
      w_spec_res = ffunc_canon_nan();
      w_spec_inv = is_snan(a) || is_snan(w_b);
    end else if (is_inf(a) && is_inf(w_b) && (a.sign != w_b.sign)) begin
      w_spec_res = ffunc_canon_nan();
      w_spec_inv = 1'b1;
    end else if (is_inf(a)) begin
      w_spec_res = a;
    end else if (is_inf(w_b)) begin
      w_spec_res = w_b;
    end else begin
      w_spec_res.sign = a.sign & w_b.sign;
    end
  end

  // Operand ordering: X is the larger magnitude, d = saturated exponent gap.
  logic          w_a_ge;
  float_t        w_xf, w_yf;
  logic [E-1:0]  w_ediff;
  logic [DW-1:0] w_dsat;
  assign w_a_ge  = {a.exp, a.man} >= {w_b.exp, w_b.man};
  assign w_xf    = w_a_ge ? a : w_b;
  assign w_yf    = w_a_ge ? w_b : a;
  assign w_ediff = eff_exp(w_xf) - eff_exp(w_yf);
  assign w_dsat  = (w_ediff > E'(DMAX)) ? DW'(DMAX) : DW'(w_ediff);

  // RNE rounding of the normalised significand.
  logic          w_rup, w_inexact, w_ovf;
  logic [M+1:0]  w_sig;
  logic [XW-1:0] w_rexp;
  logic [M-1:0]  w_rman;
  always_comb begin
    w_inexact = |r_x[2:0];
    w_rup     = r_x[2] & (r_x[1] | r_x[0] | r_x[3]);
    w_sig     = {1'b0, r_x[SW-2:3]} + (M+2)'(w_rup);
    // Carry-out bumps the exponent; a subnormal reaching 1.0 gets exponent 1.
    w_rexp    = w_sig[M+1] ? (r_ex + XW'(1)) : (w_sig[M] ? r_ex : '0);
    w_rman    = w_sig[M+1] ? w_sig[M:1] : w_sig[M-1:0];
    w_ovf     = w_rexp >= XW'({E{1'b1}});
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt     = r_state;
    w_sx_nxt        = r_sx;
    w_sub_eff_nxt   = r_sub_eff;
    w_ex_nxt        = r_ex;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_d_nxt         = r_d;
    w_res_nxt       = r_res;
    w_flags_nxt     = r_flags;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (w_special) begin
            w_res_nxt   = w_spec_res;
            w_flags_nxt = {w_spec_inv, 2'b00};
            w_state_nxt = DONE;
          end else begin
            w_sx_nxt      = w_xf.sign;
            w_sub_eff_nxt = a.sign ^ w_b.sign;
            w_ex_nxt      = XW'(eff_exp(w_xf));
            w_x_nxt       = unpack_sig(w_xf);
            w_y_nxt       = unpack_sig(w_yf);
            w_d_nxt       = w_dsat;
            w_state_nxt   = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (r_d != '0) begin
          w_y_nxt = {1'b0, r_y[SW-1:2], r_y[1] | r_y[0]};
          w_d_nxt = r_d - DW'(1);
        end else begin
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        w_x_nxt     = r_sub_eff ? (r_x - r_y) : (r_x + r_y);
        w_state_nxt = NORM;
      end
      NORM: begin
        if (r_x == '0) begin
          w_sx_nxt    = 1'b0;
          w_state_nxt = ROUND;
        end else if (r_x[SW-1]) begin
          w_x_nxt     = {1'b0, r_x[SW-1:2], r_x[1] | r_x[0]};
          w_ex_nxt    = r_ex + XW'(1);
          w_state_nxt = ROUND;
        end else if (!r_x[SW-2] && (r_ex > XW'(1))) begin
          w_x_nxt     = {r_x[SW-2:0], 1'b0};
          w_ex_nxt    = r_ex - XW'(1);
        end else begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_res_nxt.sign = r_sx;
        if (w_ovf) begin
          w_res_nxt.exp = '1;
          w_res_nxt.man = '0;
          w_flags_nxt   = 3'b011;
        end else begin
          w_res_nxt.exp = w_rexp[E-1:0];
          w_res_nxt.man = w_rman;
          w_flags_nxt   = {2'b00, w_inexact};
        end
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = DONE;
      end
      DONE: begin
        // Special results arrive here without out_valid; present them next cycle.
        if (!r_out_valid) begin
          w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sx        <= 1'b0;
      r_sub_eff   <= 1'b0;
      r_ex        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_d         <= '0;
      r_res       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sx        <= w_sx_nxt;
      r_sub_eff   <= w_sub_eff_nxt;
      r_ex        <= w_ex_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_d         <= w_d_nxt;
      r_res       <= w_res_nxt;
      r_flags     <= w_flags_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_svfloat_addsub_seq.sv
// Directed bench for svfloat_addsub_seq: reset values, normal and special
// operand vectors with latency, output hold under back-pressure, reset abort.
module tb_svfloat_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  svfloat_addsub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic [31:0] vr;
    logic [2:0]  vf;
    int          vl;
    string       name;
  } vec_t;

  // Drive one operation with out_ready high; returns result, flags and
  // accept-to-valid latency (-1 when the result never appears).
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        output logic [31:0] ores, output logic [2:0] oflags, output int lat);
    bit got;
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; ores = '0; oflags = '0; got = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1; lat = i; ores = res; oflags = flags;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_res got=%h exp=00000000", res); end
    total++; if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic run_table(input vec_t v[$]);
    logic [31:0] r; logic [2:0] f; int l;
    foreach (v[i]) begin
      run_op(v[i].va, v[i].vb, v[i].vs, r, f, l);
      total++; if (r !== v[i].vr) begin bad++; $display("FAIL %s_res got=%h exp=%h", v[i].name, r, v[i].vr); end
      total++; if (f !== v[i].vf) begin bad++; $display("FAIL %s_flags got=%b exp=%b", v[i].name, f, v[i].vf); end
      total++; if (l != v[i].vl) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", v[i].name, l, v[i].vl); end
    end
  endtask

  task automatic test_normal();
    vec_t v[$];
    v.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4,  "add_1p1"});
    v.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4,  "sub_1m1"});
    v.push_back('{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 30, "align_sat"});
    v.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 5,  "sub_3m1"});
    v.push_back('{32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 3'b000, 6,  "sub_lnorm"});
    v.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 4,  "subnorm_add"});
    run_table(v);
  endtask

  task automatic test_overflow();
    vec_t v[$];
    v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 4, "max_plus_max"});
    run_table(v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1, "inf_minf"});
    v.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1, "inf_sub_inf"});
    v.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1, "snan"});
    v.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 1, "qnan"});
    v.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 1, "one_sub_inf"});
    v.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1, "mz_plus_mz"});
    v.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000, 1, "mz_sub_mz"});
    run_table(v);
  endtask

  task automatic test_hold_and_abort();
    bit got, stale;
    logic [31:0] r; logic [2:0] f; int l;
    // Back-pressure: result held, new operands ignored.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'h40400000; got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL hold_valid_timeout got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || res !== 32'h40000000 || flags !== 3'b000 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d got=v%b r%h f%b rdy%b exp=v1 r40000000 f000 rdy0",
                 i, out_valid, res, flags, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready);
    end
    // Reset during ALIGN aborts the operation.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h30800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || res !== 32'h0) begin
      bad++; $display("FAIL abort_in_reset got=v%b rdy%b r%h exp=v0 rdy0 r00000000", out_valid, in_ready, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    total++; if (stale) begin bad++; $display("FAIL abort_stale_result got=1 exp=0"); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", in_ready); end
    run_op(32'h40400000, 32'h3F800000, 1'b0, r, f, l);
    total++; if (r !== 32'h40800000 || l != 5) begin
      bad++; $display("FAIL abort_recover got=%h lat%0d exp=40800000 lat5", r, l);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_special();
    test_hold_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
